// File: rtl/rr_capture_arbiter.sv
// Round-robin arbiter sharing one registered DW-bit capture stage among N_REQ requesters.
// Latency: request to grant 1 edge, grant to first captured beat 1 further edge; no bubble on re-grant.
// No downstream backpressure: a granted requester is captured every edge it holds i_req, up to MAX_BURST beats.
module rr_capture_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4,
  parameter int IW        = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ*DW-1:0] i_data,
  output logic [N_REQ-1:0]   o_gnt,
  output logic               o_valid,
  output logic [DW-1:0]      o_data,
  output logic [IW-1:0]      o_src,
  output logic               o_busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Beat counter is 4 bits, enough for MAX_BURST up to 15.
  localparam logic [3:0] CNT_LAST = 4'(MAX_BURST - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_REQ - 1);

  logic [0:0]       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic             valid_q, valid_d;
  logic [DW-1:0]    data_q, data_d;
  logic [IW-1:0]    src_q, src_d;

  logic [IW-1:0]    g_inc;
  logic [IW-1:0]    arb_start;
  logic             win_vld;
  logic [IW-1:0]    win_idx;
  logic [N_REQ-1:0] win_oh;
  logic             rel;

  // Successor of the granted index and the scan start point: in GRANT the
  // re-arbitration on release always starts just past the current holder.
  always_comb begin
    g_inc     = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    arb_start = (state_q == ST_GRANT) ? g_inc : ptr_q;
  end

  // Find the first requester at or after arb_start, wrapping modulo N_REQ.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_vld && i_req[(int'(arb_start) + i) % N_REQ]) begin
        win_vld = 1'b1;
        win_idx = IW'((int'(arb_start) + i) % N_REQ);
      end
    end
    win_oh = N_REQ'(1) << win_idx;
  end

  // Next-state logic: grant, beat capture, burst limit and early-drop release.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    valid_d = 1'b0;
    data_d  = data_q;
    src_d   = src_q;
    rel     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_GRANT;
          gnt_d   = win_oh;
          idx_d   = win_idx;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (i_req[idx_q]) begin
          valid_d = 1'b1;
          data_d  = i_data[int'(idx_q)*DW +: DW];
          src_d   = idx_q;
          if (cnt_q == CNT_LAST) begin
            rel = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          // Early drop: output data/src keep the last captured beat.
          rel = 1'b1;
        end
        if (rel) begin
          ptr_d = g_inc;
          if (win_vld) begin
            gnt_d = win_oh;
            idx_d = win_idx;
            cnt_d = '0;
          end else begin
            gnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by rstn.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign o_gnt   = gnt_q;
  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_src   = src_q;
  assign o_busy  = (state_q == ST_GRANT);

endmodule

// File: tb/tb_rr_capture_arbiter.sv
// Bench for rr_capture_arbiter: behavioural reference plus directed literal checks.
// Inputs change 2 time units after each rising edge; outputs are compared on falling edges.
// The reference is reset together with the DUT and stepped on every rising edge.
module tb_rr_capture_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk;
  logic          rstn;
  logic [N-1:0]  i_req;
  logic [N*DW-1:0] i_data;
  logic [N-1:0]  o_gnt;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic [1:0]    o_src;
  logic          o_busy;

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 0;

  rr_capture_arbiter #(.N_REQ(N), .DW(DW), .MAX_BURST(MB), .IW(2)) dut (
    .clk(clk), .rstn(rstn), .i_req(i_req), .i_data(i_data),
    .o_gnt(o_gnt), .o_valid(o_valid), .o_data(o_data), .o_src(o_src), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: who holds the stage, how many beats it has had, where the
  // round-robin scan resumes, and what the capture register shows.
  bit        m_busy = 0;
  int        m_g    = 0;
  int        m_cnt  = 0;
  int        m_ptr  = 0;
  bit        m_vld  = 0;
  logic [7:0] m_data = 0;
  int        m_src  = 0;

  function automatic int first_from(logic [N-1:0] req, int start);
    for (int i = 0; i < N; i++)
      if (req[(start + i) % N]) return (start + i) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rstn) begin
    int w;
    bit done;
    if (!rstn) begin
      m_busy = 0; m_g = 0; m_cnt = 0; m_ptr = 0; m_vld = 0; m_data = 0; m_src = 0;
    end else if (!m_busy) begin
      m_vld = 0;
      w = first_from(i_req, m_ptr);
      if (w >= 0) begin m_busy = 1; m_g = w; m_cnt = 0; end
    end else begin
      done = 0;
      if (i_req[m_g]) begin
        m_vld = 1; m_data = i_data[m_g*DW +: DW]; m_src = m_g;
        m_cnt++;
        if (m_cnt == MB) done = 1;
      end else begin
        m_vld = 0; done = 1;
      end
      if (done) begin
        m_ptr = (m_g + 1) % N;
        w = first_from(i_req, m_ptr);
        if (w >= 0) begin m_g = w; m_cnt = 0; end
        else m_busy = 0;
      end
    end
  end

  // Every falling edge: DUT outputs against the reference.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_gnt",   32'(o_gnt),   m_busy ? 32'(1 << m_g) : 32'd0);
      chk("m_valid", 32'(o_valid), 32'(m_vld));
      chk("m_data",  32'(o_data),  32'(m_data));
      chk("m_src",   32'(o_src),   32'(m_src));
      chk("m_busy",  32'(o_busy),  32'(m_busy));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_data_all();
    for (int k = 0; k < N; k++) i_data[k*DW +: DW] = 8'hA0 + 8'(k);
  endtask

  initial begin
    rstn  = 1'b1;
    i_req = '0;
    set_data_all();
    #1 rstn = 1'b0;
    cmp_en = 1;
    #1;
    chk("rst_gnt", 32'(o_gnt), 0);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_data", 32'(o_data), 0);
    chk("rst_src", 32'(o_src), 0);
    chk("rst_busy", 32'(o_busy), 0);
    tick(); tick();
    rstn = 1'b1;

    // Idle
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("idle_gnt", 32'(o_gnt), 0);
      chk("idle_valid", 32'(o_valid), 0);
      chk("idle_busy", 32'(o_busy), 0);
    end

    // Round-robin with all requesting
    i_req = 4'b1111;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 1) begin
        chk("rr_gnt0", 32'(o_gnt), 32'h1);
        chk("rr_valid0", 32'(o_valid), 0);
      end else begin
        chk("rr_src", 32'(o_src), 32'(((k - 2) / 4) % 4));
        chk("rr_data", 32'(o_data), 32'(8'hA0 + ((k - 2) / 4) % 4));
        chk("rr_valid", 32'(o_valid), 1);
        chk("rr_gnt", 32'(o_gnt), 32'(1 << (((k - 1) / 4) % 4)));
      end
    end
    i_req = 4'b0000;
    tick();
    chk("rr_end_gnt", 32'(o_gnt), 0);
    chk("rr_end_valid", 32'(o_valid), 0);

    // Early drop: scan resumes at 1, so 2 beats 0
    i_req = 4'b0101;
    tick(); chk("ed_gnt", 32'(o_gnt), 32'h4);
    tick(); tick();
    chk("ed_valid", 32'(o_valid), 1);
    chk("ed_src", 32'(o_src), 2);
    chk("ed_data", 32'(o_data), 32'hA2);
    i_req = 4'b0001;
    tick();
    chk("ed_drop_valid", 32'(o_valid), 0);
    chk("ed_drop_gnt", 32'(o_gnt), 32'h1);
    chk("ed_hold_data", 32'(o_data), 32'hA2);
    chk("ed_hold_src", 32'(o_src), 2);
    tick();
    chk("ed_next_valid", 32'(o_valid), 1);
    chk("ed_next_src", 32'(o_src), 0);
    chk("ed_next_data", 32'(o_data), 32'hA0);
    i_req = 4'b0000;
    tick();

    // Wrap: leave pointer at 3 after granting 2, then 3 and 0 together
    i_req = 4'b0100; tick(); chk("wr_gnt2", 32'(o_gnt), 32'h4);
    i_req = 4'b0000; tick(); chk("wr_idle", 32'(o_gnt), 0);
    i_req = 4'b1001; tick(); chk("wr_gnt3", 32'(o_gnt), 32'h8);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("wr_src3", 32'(o_src), 3);
      chk("wr_data3", 32'(o_data), 32'hA3);
    end
    chk("wr_gnt0", 32'(o_gnt), 32'h1);
    tick();
    chk("wr_src0", 32'(o_src), 0);
    chk("wr_valid0", 32'(o_valid), 1);
    i_req = 4'b0000;
    tick();

    // Single requester with incrementing data
    i_req = 4'b0010;
    for (int k = 1; k <= 7; k++) begin
      i_data[1*DW +: DW] = 8'h10 + 8'((k >= 2) ? k - 2 : 0);
      tick();
      chk("sg_gnt", 32'(o_gnt), 32'h2);
      chk("sg_busy", 32'(o_busy), 1);
      if (k == 1) chk("sg_valid0", 32'(o_valid), 0);
      else begin
        chk("sg_valid", 32'(o_valid), 1);
        chk("sg_src", 32'(o_src), 1);
        chk("sg_data", 32'(o_data), 32'(8'h10 + k - 2));
      end
    end

    // Asynchronous reset mid-burst
    rstn = 1'b0;
    #1;
    chk("ar_gnt", 32'(o_gnt), 0);
    chk("ar_valid", 32'(o_valid), 0);
    chk("ar_data", 32'(o_data), 0);
    chk("ar_src", 32'(o_src), 0);
    chk("ar_busy", 32'(o_busy), 0);
    set_data_all();
    tick();
    rstn = 1'b1;
    i_req = 4'b1111;
    tick(); chk("ar_regnt", 32'(o_gnt), 32'h1);
    tick();
    chk("ar_src0", 32'(o_src), 0);
    chk("ar_data0", 32'(o_data), 32'hA0);

    i_req = 4'b0000;
    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
